pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Controller that sequences the 16-bit program counter register for the CPU core. It turns high-level PC commands from the instruction decoder into the counter's increment and load strobes:
- INC: increment.
- JUMP: absolute load.
- BRANCH: signed relative branch, with the 6502 extra cycle on page crossing.
- VECTOR: two-byte vector fetch from memory.
It also performs the reset-vector fetch automatically after reset.

Parameters:
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RESET, 16'hFFFC, reset vector low-byte address
VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address
AUTO_RESET_VECTOR, 1, 1 = fetch reset vector after reset release; 0 = go straight to IDLE

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
cmd_op  in  2  0=INC, 1=JUMP, 2=BRANCH, 3=VECTOR
cmd_data  in  16  JUMP: target; BRANCH: [7:0] signed offset; VECTOR: [1:0] select (0=RESET, 1=NMI, 2/3=IRQ)
pc_l_in  in  8  current PC low byte from the counter
pc_h_in  in  8  current PC high byte from the counter
pc_inc  out  1  increment strobe to the counter
pc_load  out  1  load strobe to the counter
pc_l_out  out  8  load value, low byte
pc_h_out  out  8  load value, high byte
mem_req  out  1  memory read request
mem_addr  out  16  memory read address
mem_ack  in  1  read data valid this cycle
mem_rdata  in  8  read data
page_cross  out  1  one-cycle pulse during the BRANCH high-byte fix-up cycle
busy  out  1  state != IDLE

Behaviour:
- Outputs are Moore (decoded from state and internal registers only). No combinational path from any input to any output.
- pc_inc and pc_load are never high together. pc_l_out/pc_h_out are 0 whenever pc_load=0.
- While reset is low:
  - State = BOOT; all registers 0.
  - Every output is 0, including cmd_ready and busy.
  - Assertion mid-operation aborts immediately, with no partial strobes.
- States: BOOT, IDLE, INC, JUMP, BR_LO, BR_HI, VEC_LO, VEC_HI, VEC_LOAD.
- BOOT: the first clk edge after reset release goes to VEC_LO with vec=VEC_RESET if AUTO_RESET_VECTOR=1, else to IDLE. busy=1 in BOOT.
- IDLE: cmd_ready=1, and only in IDLE. On acceptance, cmd_data, pc_l_in and pc_h_in are latched, and the FSM moves to:
  - op 0 -> INC
  - op 1 -> JUMP
  - op 2 -> BR_LO
  - op 3 -> VEC_LO
- INC: pc_inc=1 for exactly one cycle, then IDLE.
- JUMP: pc_load=1, out = target, one cycle, then IDLE.
- BR_LO:
  - sum = {1'b0, pcl_latched} + {1'b0, off[7:0]} (9 bits).
  - pc_load=1, out = {pch_latched, sum[7:0]}.
  - Crossing occurs when sum[8] != off[7]. On crossing go to BR_HI, else IDLE.
- BR_HI:
  - pc_load=1, page_cross=1.
  - out = {pch_latched + 1, sum[7:0]} if off[7]=0, else {pch_latched - 1, sum[7:0]}, mod 256. FFxx wraps to 00xx and 00xx wraps to FFxx.
  - Then IDLE.
  - Branch latency: 1 cycle without crossing, 2 cycles with crossing.
- VEC_LO:
  - mem_req=1, mem_addr=vec, held stable until mem_ack.
  - On the mem_ack cycle, lo <= mem_rdata and the FSM goes to VEC_HI.
  - mem_ack while mem_req=0 is ignored.
- VEC_HI:
  - mem_req=1, mem_addr=vec+1, held stable until mem_ack.
  - On mem_ack, hi <= mem_rdata and the FSM goes to VEC_LOAD.
  - mem_req drops for at least one cycle between the two reads, because VEC_HI re-asserts it from a fresh state. mem_ack in the same cycle the request is first raised is legal (zero wait).
- VEC_LOAD: pc_load=1, out = {hi, lo}, one cycle, then IDLE.
- No timeout: the FSM waits indefinitely for mem_ack.
- cmd_valid while not IDLE is ignored, and the command is not lost: it remains pending until cmd_ready.

Test Plan:
- Boot: AUTO_RESET_VECTOR=1, release reset, memory acks with a 2-cycle wait returning 0x00 @FFFC and 0x80 @FFFD. Required: mem_addr FFFC then FFFD; exactly one pc_load with 0x8000; cmd_ready rises the cycle after VEC_LOAD.
- INC/JUMP: INC accepted -> pc_inc high exactly 1 cycle. JUMP 0x1234 -> pc_load with 0x1234 for 1 cycle. Back-to-back commands: each accepted only when cmd_ready=1.
- Branch without crossing: PC=0x8010, offset 0x05 -> single pc_load 0x8015, page_cross=0. PC=0x8010, offset 0xFE -> 0x800E.
- Branch with crossing:
  - PC=0x80F0, off 0x20 -> loads 0x8010 then 0x8110, page_cross high in the second cycle only.
  - PC=0x8005, off 0xF0 -> 0x80F5 then 0x7FF5.
  - PC=0xFFF0, off 0x20 -> 0xFF10 then 0x0010.
- VECTOR NMI with zero-wait ack: reads FFFA/FFFB returning 0x34/0x12 -> pc_load 0x1234. Select 3 behaves as IRQ (FFFE/FFFF).
- Reset mid-fetch: assert reset in VEC_HI -> all outputs 0 asynchronously; after release the full boot fetch restarts at FFFC, with no pc_load from the aborted fetch.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Turns high-level program-counter commands from the instruction decoder into
// increment / load strobes for the 16-bit PC register, including the 6502
// style page-crossing fix-up cycle on relative branches and the two-byte
// vector fetch from memory.  After reset release the reset vector is fetched
// automatically (AUTO_RESET_VECTOR=1).
//
// Handshake (cmd_*): a command transfers on a rising clk edge where
// cmd_valid && cmd_ready.  cmd_ready is high only in IDLE; a requester must
// hold cmd_valid/cmd_op/cmd_data stable until that edge, so a command offered
// while busy is simply held pending and never lost.  Memory reads (mem_*):
// mem_req/mem_addr stay stable until a cycle with mem_ack; mem_ack while
// mem_req=0 is ignored.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   cmd_valid  in   1   command request
//   cmd_ready  out  1   high only in IDLE
//   cmd_op     in   2   0=INC 1=JUMP 2=BRANCH 3=VECTOR
//   cmd_data   in  16   JUMP target / BRANCH offset [7:0] / VECTOR select [1:0]
//   pc_l_in    in   8   current PC low byte
//   pc_h_in    in   8   current PC high byte
//   pc_inc     out  1   increment strobe
//   pc_load    out  1   load strobe
//   pc_l_out   out  8   load value low byte (0 when pc_load=0)
//   pc_h_out   out  8   load value high byte (0 when pc_load=0)
//   mem_req    out  1   memory read request
//   mem_addr   out 16   memory read address
//   mem_ack    in   1   read data valid
//   mem_rdata  in   8   read data
//   page_cross out  1   pulse in the branch high-byte fix-up cycle
//   busy       out  1   state != IDLE (0 while reset is asserted)
//   dbg_state  out  4   current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [15:0] VEC_NMI           = 16'hFFFA,
    parameter logic [15:0] VEC_RESET         = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ           = 16'hFFFE,
    parameter bit          AUTO_RESET_VECTOR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [7:0]  pc_l_in,
    input  logic [7:0]  pc_h_in,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [7:0]  pc_l_out,
    output logic [7:0]  pc_h_out,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        page_cross,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_IDLE     = 4'd1,
        S_INC      = 4'd2,
        S_JUMP     = 4'd3,
        S_BR_LO    = 4'd4,
        S_BR_HI    = 4'd5,
        S_VEC_LO   = 4'd6,
        S_VEC_HI   = 4'd7,
        S_VEC_LOAD = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q;     // latched cmd_data
    logic [7:0]  pcl_q;      // latched PC low byte
    logic [7:0]  pch_q;      // latched PC high byte
    logic [15:0] vec_q;      // vector low-byte address
    logic [7:0]  lo_q;       // fetched vector low byte
    logic [7:0]  hi_q;       // fetched vector high byte
    logic        gap_q;      // first VEC_HI cycle: request held low

    logic        cmd_accept;
    logic [8:0]  br_sum;
    logic        br_cross;
    logic [7:0]  br_pch_fix;
    logic [15:0] vec_sel;

    assign cmd_accept = cmd_valid && cmd_ready;

    // Relative branch arithmetic, all from latched values.  A crossing is
    // signalled by the carry disagreeing with the offset sign: a forward
    // offset that carries, or a backward offset that does not.
    assign br_sum     = {1'b0, pcl_q} + {1'b0, data_q[7:0]};
    assign br_cross   = (br_sum[8] != data_q[7]);
    assign br_pch_fix = data_q[7] ? (pch_q - 8'd1) : (pch_q + 8'd1);

    always_comb begin
        vec_sel = VEC_IRQ;
        case (cmd_data[1:0])
            2'd0:    vec_sel = VEC_RESET;
            2'd1:    vec_sel = VEC_NMI;
            default: vec_sel = VEC_IRQ;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            data_q  <= '0;
            pcl_q   <= '0;
            pch_q   <= '0;
            vec_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_accept) begin
                data_q <= cmd_data;
                pcl_q  <= pc_l_in;
                pch_q  <= pc_h_in;
                if (cmd_op == 2'd3) begin
                    vec_q <= vec_sel;
                end
            end
            if (state_q == S_BOOT) begin
                vec_q <= VEC_RESET;
            end
            if (state_q == S_VEC_LO && mem_ack) begin
                lo_q <= mem_rdata;
            end
            if (state_q == S_VEC_HI && mem_req && mem_ack) begin
                hi_q <= mem_rdata;
            end
            gap_q <= (state_q == S_VEC_LO) && mem_ack;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: begin
                state_d = AUTO_RESET_VECTOR ? S_VEC_LO : S_IDLE;
            end
            S_IDLE: begin
                if (cmd_accept) begin
                    case (cmd_op)
                        2'd0:    state_d = S_INC;
                        2'd1:    state_d = S_JUMP;
                        2'd2:    state_d = S_BR_LO;
                        default: state_d = S_VEC_LO;
                    endcase
                end
            end
            S_INC:      state_d = S_IDLE;
            S_JUMP:     state_d = S_IDLE;
            S_BR_LO:    state_d = br_cross ? S_BR_HI : S_IDLE;
            S_BR_HI:    state_d = S_IDLE;
            S_VEC_LO: begin
                if (mem_ack) begin
                    state_d = S_VEC_HI;
                end
            end
            S_VEC_HI: begin
                // An ack during the gap cycle has no request behind it.
                if (mem_req && mem_ack) begin
                    state_d = S_VEC_LOAD;
                end
            end
            S_VEC_LOAD: state_d = S_IDLE;
            default:    state_d = S_BOOT;
        endcase
    end

    // ---------------------------------------------------------------------
    // Moore outputs, decoded from state and registers only
    // ---------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_l_out   = 8'h00;
        pc_h_out   = 8'h00;
        mem_req    = 1'b0;
        mem_addr   = 16'h0000;
        page_cross = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_INC: begin
                pc_inc = 1'b1;
            end
            S_JUMP: begin
                pc_load  = 1'b1;
                pc_l_out = data_q[7:0];
                pc_h_out = data_q[15:8];
            end
            S_BR_LO: begin
                pc_load  = 1'b1;
                pc_l_out = br_sum[7:0];
                pc_h_out = pch_q;
            end
            S_BR_HI: begin
                pc_load    = 1'b1;
                page_cross = 1'b1;
                pc_l_out   = br_sum[7:0];
                pc_h_out   = br_pch_fix;
            end
            S_VEC_LO: begin
                mem_req  = 1'b1;
                mem_addr = vec_q;
            end
            S_VEC_HI: begin
                // Request is re-raised one cycle after entry so the bus sees
                // a clean low cycle between the two reads.
                mem_req  = !gap_q;
                mem_addr = vec_q + 16'd1;
            end
            S_VEC_LOAD: begin
                pc_load  = 1'b1;
                pc_l_out = lo_q;
                pc_h_out = hi_q;
            end
            default: begin
            end
        endcase
    end

    // busy covers BOOT too, but must read 0 while reset is held; the reset
    // pin is the only input allowed to reach an output, and only to clear it.
    assign busy      = reset && (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed, table-driven bench for pc_sequencer.  Each table row issues one
// command and lists the strobes it must produce; a per-cycle monitor with a
// small memory model collects pc_inc / pc_load / page_cross activity and the
// addresses read, and compares them with the row.  Hand-written sequences
// cover boot, back-to-back commands, stray acks and reset mid-fetch.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = 16'h0;
    logic [7:0]  pc_l_in = 8'h0;
    logic [7:0]  pc_h_in = 8'h0;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_l_out;
    logic [7:0]  pc_h_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        page_cross;
    logic        busy;
    logic [3:0]  dbg_state;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .pc_l_in    (pc_l_in),
        .pc_h_in    (pc_h_in),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_l_out   (pc_l_out),
        .pc_h_out   (pc_h_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .page_cross (page_cross),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] pc;
        int          wait_cyc;   // memory wait states per read
        int          n_inc;
        int          n_load;
        logic [15:0] ld0;
        logic [15:0] ld1;
        int          n_cross;
        int          n_addr;
        logic [15:0] a0;
        logic [15:0] a1;
        int          lat;        // busy cycles after acceptance
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        case (a)
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h80;
            16'hFFFA: return 8'h34;
            16'hFFFB: return 8'h12;
            16'hFFFE: return 8'hCD;
            16'hFFFF: return 8'hAB;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [43:0] all_outputs();
        return {cmd_ready, pc_inc, pc_load, pc_l_out, pc_h_out, mem_req,
                mem_addr, page_cross, busy};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input vec_t r);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({r.name, ":ready_before_issue"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = r.op;
        cmd_data  = r.data;
        pc_l_in   = r.pc[7:0];
        pc_h_in   = r.pc[15:8];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 16'($urandom_range(0, 65535));
        pc_l_in   = 8'($urandom_range(0, 255));
        pc_h_in   = 8'($urandom_range(0, 255));
    endtask

    // ---------------- monitor + memory model ----------------
    // Starts on the first negedge after the acceptance (or boot) edge and
    // runs until cmd_ready is seen.
    task automatic observe(input vec_t r);
        int cyc = 0;
        int n_inc = 0;
        int n_load = 0;
        int n_cross = 0;
        int ready_cyc = -1;
        int req_cnt = 0;
        logic cross_last = 1'b0;
        logic [15:0] addr_q[$];
        logic [15:0] e;
        exp_q.delete();
        if (r.n_load >= 1) exp_q.push_back(r.ld0);
        if (r.n_load >= 2) exp_q.push_back(r.ld1);
        while (ready_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cmd_ready) begin
                ready_cyc = cyc;
                mem_ack = 1'b0;
            end else begin
                check({r.name, ":inc_load_exclusive"}, {31'd0, pc_inc & pc_load}, 0);
                if (!pc_load)
                    check({r.name, ":out_zero_no_load"}, {16'd0, pc_h_out, pc_l_out}, 0);
                if (pc_inc) n_inc++;
                if (page_cross) n_cross++;
                if (pc_load) begin
                    n_load++;
                    cross_last = page_cross;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({r.name, ":load_value"}, {pc_h_out, pc_l_out}, e);
                    end else begin
                        check({r.name, ":unexpected_load"}, n_load, r.n_load);
                    end
                end
                if (mem_req) begin
                    if (req_cnt == r.wait_cyc) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_read(mem_addr);
                        addr_q.push_back(mem_addr);
                        req_cnt   = 0;
                    end else begin
                        mem_ack = 1'b0;
                        req_cnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    req_cnt = 0;
                end
            end
        end
        mem_ack = 1'b0;
        check({r.name, ":finished"}, {31'd0, ready_cyc > 0}, 1);
        check({r.name, ":latency"}, ready_cyc, r.lat + 1);
        check({r.name, ":n_inc"}, n_inc, r.n_inc);
        check({r.name, ":n_load"}, n_load, r.n_load);
        check({r.name, ":n_cross"}, n_cross, r.n_cross);
        if (n_cross > 0)
            check({r.name, ":cross_on_last_load"}, {31'd0, cross_last}, 1);
        check({r.name, ":n_addr"}, addr_q.size(), r.n_addr);
        if (addr_q.size() >= 1 && r.n_addr >= 1)
            check({r.name, ":addr0"}, addr_q[0], r.a0);
        if (addr_q.size() >= 2 && r.n_addr >= 2)
            check({r.name, ":addr1"}, addr_q[1], r.a1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t boot2, boot0;
        //                 name        op    data      pc        wt inc ld ld0       ld1       cr na a0        a1        lat
        tbl.push_back(vec_t'{"inc",     2'd0, 16'h0000, 16'h1000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"jump",    2'd1, 16'h1234, 16'hABCD, 0, 0, 1, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"jmp_ffff",2'd1, 16'hFFFF, 16'h0000, 0, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"br_fwd",  2'd2, 16'h0005, 16'h8010, 0, 0, 1, 16'h8015, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"br_back", 2'd2, 16'h00FE, 16'h8010, 0, 0, 1, 16'h800E, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"br_m128", 2'd2, 16'h0080, 16'h8080, 0, 0, 1, 16'h8000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1});
        tbl.push_back(vec_t'{"brx_fwd", 2'd2, 16'h0020, 16'h80F0, 0, 0, 2, 16'h8010, 16'h8110, 1, 0, 16'h0000, 16'h0000, 2});
        tbl.push_back(vec_t'{"brx_back",2'd2, 16'h00F0, 16'h8005, 0, 0, 2, 16'h80F5, 16'h7FF5, 1, 0, 16'h0000, 16'h0000, 2});
        tbl.push_back(vec_t'{"brx_wrap",2'd2, 16'h0020, 16'hFFF0, 0, 0, 2, 16'hFF10, 16'h0010, 1, 0, 16'h0000, 16'h0000, 2});
        tbl.push_back(vec_t'{"brx_uwrp",2'd2, 16'h0080, 16'h0010, 0, 0, 2, 16'h0090, 16'hFF90, 1, 0, 16'h0000, 16'h0000, 2});
        tbl.push_back(vec_t'{"brx_edge",2'd2, 16'h0001, 16'h80FF, 0, 0, 2, 16'h8000, 16'h8100, 1, 0, 16'h0000, 16'h0000, 2});
        tbl.push_back(vec_t'{"vec_nmi", 2'd3, 16'h0001, 16'h4000, 0, 0, 1, 16'h1234, 16'h0000, 0, 2, 16'hFFFA, 16'hFFFB, 4});
        tbl.push_back(vec_t'{"vec_sel3",2'd3, 16'h0003, 16'h4000, 0, 0, 1, 16'hABCD, 16'h0000, 0, 2, 16'hFFFE, 16'hFFFF, 4});
        tbl.push_back(vec_t'{"vec_irq", 2'd3, 16'hFF02, 16'h4000, 1, 0, 1, 16'hABCD, 16'h0000, 0, 2, 16'hFFFE, 16'hFFFF, 6});
        tbl.push_back(vec_t'{"vec_rst", 2'd3, 16'h0000, 16'h4000, 0, 0, 1, 16'h8000, 16'h0000, 0, 2, 16'hFFFC, 16'hFFFD, 4});

        boot2 = vec_t'{"boot",  2'd0, 16'h0, 16'h0, 2, 0, 1, 16'h8000, 16'h0, 0, 2, 16'hFFFC, 16'hFFFD, 8};
        boot0 = vec_t'{"reboot",2'd0, 16'h0, 16'h0, 0, 0, 1, 16'h8000, 16'h0, 0, 2, 16'hFFFC, 16'hFFFD, 4};

        // ---- reset state ----
        #23;
        check("reset_outputs_zero", {20'd0, all_outputs()}, 0);
        check("reset_state_boot", {28'd0, dbg_state}, 0);

        // ---- boot fetch with 2 wait states ----
        @(negedge clk);
        reset = 1'b1;
        observe(boot2);

        // ---- table ----
        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i]);
            observe(tbl[i]);
        end

        // ---- back-to-back: INC held pending behind a JUMP ----
        @(negedge clk);
        check("b2b:ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = 16'h4321;
        @(posedge clk);
        #1;
        cmd_op   = 2'd0;
        cmd_data = 16'h0000;
        @(negedge clk);
        check("b2b:c1_ready", cmd_ready, 0);
        check("b2b:c1_load", {15'd0, pc_load, pc_h_out, pc_l_out}, {15'd0, 1'b1, 16'h4321});
        check("b2b:c1_inc", pc_inc, 0);
        @(negedge clk);
        check("b2b:c2_ready", cmd_ready, 1);
        check("b2b:c2_strobes", {pc_inc, pc_load}, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b:c3_inc", pc_inc, 1);
        check("b2b:c3_ready", cmd_ready, 0);
        @(negedge clk);
        check("b2b:c4_inc", pc_inc, 0);
        check("b2b:c4_ready", cmd_ready, 1);

        // ---- stray ack in IDLE is ignored ----
        mem_ack   = 1'b1;
        mem_rdata = 8'h55;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack:idle", {busy, cmd_ready, mem_req, pc_load}, 4'b0100);

        // ---- reset in VEC_HI aborts the fetch ----
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid:lo_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'hFFFC});
        mem_ack   = 1'b1;
        mem_rdata = 8'h00;
        @(negedge clk);
        check("rst_mid:gap_req_low", mem_req, 0);
        check("rst_mid:gap_state", {28'd0, dbg_state}, 7);
        mem_ack   = 1'b1;       // ack with no request behind it
        mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_mid:hi_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'hFFFD});
        check("rst_mid:hi_state", {28'd0, dbg_state}, 7);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid:async_zero", {20'd0, all_outputs()}, 0);
        check("rst_mid:state_boot", {28'd0, dbg_state}, 0);
        @(negedge clk);
        reset = 1'b1;
        observe(boot0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
